// File: rtl/verdict_pkg.sv
// ---------------------------------------------------------------------------
// verdict_pkg
// Shared types and helpers for the verdict trace sink that sits behind the
// RTLola monitor (topEntity).
//   - configuration constants matching the monitor build (14 outputs,
//     64-bit values, 32-bit timestamps)
//   - verdict_rec_t : one captured record {ts, active mask, all values}
//   - verdict_state_t : serializer FSM states
//   - header field positions and the header builder
//   - next_set_bit : priority encoder used to walk the active mask
// ---------------------------------------------------------------------------
package verdict_pkg;

    localparam int VP_NUM_OUTPUTS = 14;
    localparam int VP_DATA_W      = 64;
    localparam int VP_TS_W        = 32;
    localparam int VP_DEPTH       = 8;
    localparam int BEAT_W         = 64;

    // Index register width for walking the mask (at least one bit).
    localparam int IDX_W = (VP_NUM_OUTPUTS > 1) ? $clog2(VP_NUM_OUTPUTS) : 1;

    // Header beat layout: ts in the upper half, mask in the lower half.
    localparam int HDR_FIELD_W  = 32;
    localparam int HDR_TS_LSB   = 32;
    localparam int HDR_MASK_LSB = 0;

    // Returned by next_set_bit when no further bit is set.
    localparam logic [5:0] NO_BIT = 6'd32;

    // FSM encodings kept as plain constants for older tooling, mirrored by the enum.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        HDR  = ST_HDR,
        DATA = ST_DATA
    } verdict_state_t;

    typedef struct packed {
        logic [VP_TS_W-1:0]                          ts;
        logic [VP_NUM_OUTPUTS-1:0]                   mask;
        logic [VP_NUM_OUTPUTS-1:0][VP_DATA_W-1:0]    values;
    } verdict_rec_t;

    // Lowest set bit of mask at position >= from, or NO_BIT if none.
    // Scanning downwards lets the last hit (the lowest index) win.
    function automatic logic [5:0] next_set_bit(input logic [31:0] mask,
                                                input logic [5:0]  from);
        logic [5:0] r;
        r = NO_BIT;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i] && (6'(i) >= from)) begin
                r = 6'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [BEAT_W-1:0] make_header(input logic [31:0] ts,
                                                      input logic [31:0] mask);
        logic [BEAT_W-1:0] h;
        h = '0;
        h[HDR_TS_LSB   +: HDR_FIELD_W] = ts;
        h[HDR_MASK_LSB +: HDR_FIELD_W] = mask;
        return h;
    endfunction

endpackage

// File: rtl/verdict_fifo.sv
// ---------------------------------------------------------------------------
// verdict_fifo
// Record FIFO for the verdict serializer. The head record is presented from
// a register (registered RAM read); a push into an otherwise empty FIFO is
// forwarded straight into that register so the head is valid one edge after
// the push.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write one record (caller guarantees !full)
//   pop               drop the head record (caller guarantees !empty)
//   head              current head record (valid while !empty)
//   count             registered occupancy
//   full, empty       registered flags derived from the next count
// ---------------------------------------------------------------------------
module verdict_fifo
    import verdict_pkg::*;
#(
    parameter int DEPTH = VP_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  verdict_rec_t           push_data,
    input  logic                   pop,
    output verdict_rec_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    verdict_rec_t mem [DEPTH];

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             full_reg;
    logic             empty_reg;
    logic             head_fwd;
    verdict_rec_t     head_reg;

    always_comb begin
        rd_ptr_next = rd_ptr_reg + AW'(pop);
        count_next  = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // The incoming record becomes the head when it lands exactly where the
    // read pointer will point after this edge (FIFO empty, or emptying).
    assign head_fwd = push && (wr_ptr_reg == rd_ptr_next);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(push);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            full_reg   <= (count_next == CNT_W'(DEPTH));
            empty_reg  <= (count_next == '0);
            head_reg   <= head_fwd ? push_data : mem[rd_ptr_next];
        end
    end

    assign head  = head_reg;
    assign count = count_reg;
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/verdict_serializer.sv
// ---------------------------------------------------------------------------
// verdict_serializer
// Trace sink for the RTLola monitor. Every en cycle with at least one active
// output captures {ts, out_aktv, out_data} into a record FIFO; records are
// streamed as packets of 64-bit beats: one header beat {ts, mask} followed by
// one beat per active output in ascending index order.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   en                    monitor clock enable (gates ts and capture only)
//   out_data, out_aktv    monitor output values and active flags
//   m_data/m_valid/m_last stream beat, valid, end-of-packet
//   m_ready               sink ready
//   overflow              sticky flag: a record was dropped since reset
//   drop_count            dropped records, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module verdict_serializer
    import verdict_pkg::*;
#(
    parameter int NUM_OUTPUTS = VP_NUM_OUTPUTS,
    parameter int DATA_W      = VP_DATA_W,
    parameter int DEPTH       = VP_DEPTH,
    parameter int TS_W        = VP_TS_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_OUTPUTS*DATA_W-1:0] out_data,
    input  logic [NUM_OUTPUTS-1:0]        out_aktv,
    output logic [63:0]                   m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic                          overflow,
    output logic [15:0]                   drop_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // The record layout is fixed by the package; reject builds that disagree.
    if (NUM_OUTPUTS != VP_NUM_OUTPUTS || DATA_W != VP_DATA_W || TS_W != VP_TS_W ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_cfg_check
        $error("verdict_serializer: parameters do not match verdict_pkg record layout");
    end

    // ---------------- timestamp ----------------
    logic [TS_W-1:0] ts_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_reg <= '0;
        end else if (en) begin
            ts_reg <= ts_reg + TS_W'(1);
        end
    end

    // ---------------- capture ----------------
    logic [NUM_OUTPUTS-1:0][DATA_W-1:0] cap_values;
    verdict_rec_t                       cap_rec;

    for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_unpack
        assign cap_values[gi] = out_data[gi*DATA_W +: DATA_W];
    end

    assign cap_rec = {ts_reg, out_aktv, cap_values};

    logic             capture;
    logic             push;
    logic             drop;
    logic             pop;
    verdict_rec_t     head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    // fifo_full is registered, so a pop on this edge cannot make room for
    // a capture on the same edge.
    assign capture = en && (|out_aktv);
    assign push    = capture && !fifo_full;
    assign drop    = capture && fifo_full;

    verdict_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (cap_rec),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---------------- drop accounting ----------------
    logic        overflow_reg;
    logic [15:0] drop_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
            if (drop_count_reg != 16'hFFFF) begin
                drop_count_reg <= drop_count_reg + 16'd1;
            end
        end
    end

    // ---------------- serializer FSM ----------------
    // The record being sent stays at the FIFO head until its last beat is
    // accepted, so it keeps occupying a slot for the whole packet.
    verdict_state_t   state_reg;
    verdict_state_t   state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] idx_next;
    logic [5:0]       first_bit;
    logic [5:0]       after_bit;
    logic             fire;
    logic             at_last;

    assign first_bit = next_set_bit(32'(head.mask), 6'd0);
    assign after_bit = next_set_bit(32'(head.mask), 6'(idx_reg) + 6'd1);
    assign fire      = m_valid && m_ready;
    assign at_last   = (state_reg == DATA) && (after_bit == NO_BIT);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                // A push into the empty FIFO is forwarded to the head register
                // on this same edge, so the header can go out next cycle.
                if (!fifo_empty || push) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                if (fire) begin
                    state_next = DATA;
                    idx_next   = IDX_W'(first_bit);
                end
            end
            DATA: begin
                if (fire) begin
                    if (at_last) begin
                        pop = 1'b1;
                        // Another record already queued, or arriving now into
                        // the slot behind the head: continue without a bubble.
                        if ((fifo_count > CNT_W'(1)) || push) begin
                            state_next = HDR;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        idx_next = IDX_W'(after_bit);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // ---------------- stream outputs ----------------
    // Driven purely from registered state and the registered head, so they
    // are stable while stalled and drop to zero as soon as reset asserts.
    always_comb begin
        m_data = '0;
        case (state_reg)
            HDR:     m_data = make_header(32'(head.ts), 32'(head.mask));
            DATA:    m_data = head.values[idx_reg];
            default: m_data = '0;
        endcase
    end

    assign m_valid    = (state_reg != IDLE);
    assign m_last     = at_last;
    assign overflow   = overflow_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_verdict_serializer.sv
module tb_verdict_serializer;

    localparam int N = 14;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic [N*64-1:0] out_data = '0;
    logic [N-1:0]    out_aktv = '0;
    logic [63:0]     m_data;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic            m_last;
    logic            overflow;
    logic [15:0]     drop_count;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    verdict_serializer #(
        .NUM_OUTPUTS (N),
        .DATA_W      (64),
        .DEPTH       (8),
        .TS_W        (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .out_data   (out_data),
        .out_aktv   (out_aktv),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        m_ready  = 1'b0;
        out_aktv = '0;
        out_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;
    endtask

    task automatic set_val(input int i, input logic [63:0] v);
        out_data[i*64 +: 64] = v;
    endtask

    // Check the presented beat, then advance one cycle (m_ready set by caller).
    task automatic beat(input string tag, input logic [63:0] d, input logic l);
        chk({tag, ".valid"}, 64'(m_valid), 64'd1);
        chk({tag, ".data"},  m_data, d);
        chk({tag, ".last"},  64'(m_last), 64'(l));
        tick();
    endtask

    // Hold m_ready low for 'hold' cycles checking stability, then accept.
    task automatic stalled_beat(input string tag, input logic [63:0] d, input logic l,
                                input int hold);
        m_ready = 1'b0;
        for (int c = 0; c < hold; c++) begin
            chk({tag, ".hold_valid"}, 64'(m_valid), 64'd1);
            chk({tag, ".hold_data"},  m_data, d);
            chk({tag, ".hold_last"},  64'(m_last), 64'(l));
            tick();
        end
        m_ready = 1'b1;
        beat(tag, d, l);
        m_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------- reset state + single event ----------
        do_reset();
        chk("rst.valid", 64'(m_valid), 64'd0);
        chk("rst.last",  64'(m_last), 64'd0);
        chk("rst.data",  m_data, 64'd0);
        chk("rst.ovf",   64'(overflow), 64'd0);
        chk("rst.drops", 64'(drop_count), 64'd0);

        m_ready = 1'b1;
        repeat (5) tick();
        out_aktv = 14'h0005;
        set_val(0, 64'd1);
        set_val(2, 64'hFFFF_FFFF_FFFF_FFFD);
        tick();
        out_aktv = '0;
        beat("single.hdr", 64'h0000_0005_0000_0005, 1'b0);
        beat("single.v0",  64'd1, 1'b0);
        beat("single.v2",  64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        chk("single.after", 64'(m_valid), 64'd0);

        // ---------- backpressure ----------
        do_reset();
        repeat (5) tick();
        out_aktv = 14'h0005;
        set_val(0, 64'd1);
        set_val(2, 64'hFFFF_FFFF_FFFF_FFFD);
        tick();
        out_aktv = '0;
        stalled_beat("bp.hdr", 64'h0000_0005_0000_0005, 1'b0, 4);
        stalled_beat("bp.v0",  64'd1, 1'b0, 4);
        stalled_beat("bp.v2",  64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 4);
        chk("bp.after", 64'(m_valid), 64'd0);
        tick();
        chk("bp.after2", 64'(m_valid), 64'd0);

        // ---------- all outputs active ----------
        do_reset();
        m_ready = 1'b1;
        repeat (3) tick();
        out_aktv = 14'h3FFF;
        for (int i = 0; i < N; i++) set_val(i, 64'(100 + i));
        tick();
        out_aktv = '0;
        beat("all.hdr", 64'h0000_0003_0000_3FFF, 1'b0);
        for (int k = 0; k < N; k++) begin
            beat($sformatf("all.v%0d", k), 64'(100 + k), (k == N - 1));
        end
        chk("all.after", 64'(m_valid), 64'd0);

        // ---------- overflow ----------
        do_reset();
        m_ready = 1'b0;
        repeat (20) tick();
        out_aktv = 14'h0001;
        for (int k = 0; k < 10; k++) begin
            set_val(0, 64'(1000 + k));
            tick();
        end
        out_aktv = '0;
        chk("ovf.drops", 64'(drop_count), 64'd2);
        chk("ovf.flag",  64'(overflow), 64'd1);
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [63:0] h;
            h = {32'(20 + k), 32'h0000_0001};
            beat($sformatf("ovf.p%0d.hdr", k), h, 1'b0);
            beat($sformatf("ovf.p%0d.v0", k), 64'(1000 + k), 1'b1);
        end
        chk("ovf.after", 64'(m_valid), 64'd0);

        // ---------- en stall ----------
        do_reset();
        m_ready = 1'b1;
        repeat (3) tick();
        en       = 1'b0;
        out_aktv = 14'h0001;
        set_val(0, 64'h55);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("en.stall%0d", c), 64'(m_valid), 64'd0);
            tick();
        end
        en = 1'b1;
        tick();
        out_aktv = '0;
        beat("en.hdr", 64'h0000_0003_0000_0001, 1'b0);
        beat("en.v0",  64'h55, 1'b1);

        // ---------- reset mid-packet ----------
        do_reset();
        m_ready = 1'b1;
        repeat (2) tick();
        out_aktv = 14'h0005;
        set_val(0, 64'd7);
        set_val(2, 64'd9);
        tick();
        out_aktv = 14'h0001;
        set_val(0, 64'd11);
        beat("mid.hdr", 64'h0000_0002_0000_0005, 1'b0);
        out_aktv = '0;
        chk("mid.beat2", m_data, 64'd7);
        #2;
        rst = 1'b1;
        #1;
        chk("mid.rst_valid", 64'(m_valid), 64'd0);
        chk("mid.rst_last",  64'(m_last), 64'd0);
        chk("mid.rst_data",  m_data, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid.ovf",   64'(overflow), 64'd0);
        chk("mid.drops", 64'(drop_count), 64'd0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("mid.quiet%0d", c), 64'(m_valid), 64'd0);
            tick();
        end
        out_aktv = 14'h0002;
        set_val(1, 64'h77);
        tick();
        out_aktv = '0;
        beat("mid.new.hdr", 64'h0000_0004_0000_0002, 1'b0);
        beat("mid.new.v1",  64'h77, 1'b1);
        chk("mid.new.after", 64'(m_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/verdict_serializer.md
# verdict_serializer

Downstream of the RTLola monitor `topEntity`. Each cycle in which at least one monitor output is active, the block captures one verdict record: a cycle timestamp, the active mask and every output value. It buffers up to DEPTH records and serializes each as a variable-length packet of 64-bit beats on a valid/ready stream. This replaces per-cycle `$display` observation with a synthesizable trace sink for host readout.

## Interface
- NUM_OUTPUTS, 14, number of monitor output streams (1..32)
- DATA_W, 64, width of each signed output value; must equal the beat width (64)
- DEPTH, 8, record FIFO depth (power of two, ≥2)
- TS_W, 32, timestamp width
- clk  in  1  system clock, same domain as monitor
- rst  in  1  asynchronous, active-high reset
- en  in  1  clock enable, same signal as the monitor's en
- out_data  in  NUM_OUTPUTS*DATA_W  monitor output values, output_i at bits [i*DATA_W +: DATA_W]
- out_aktv  in  NUM_OUTPUTS  monitor output_i_aktv flags
- m_data  out  64  stream beat
- m_valid  out  1  beat valid
- m_ready  in  1  sink ready
- m_last  out  1  final beat of a packet
- overflow  out  1  sticky: at least one record dropped since reset
- drop_count  out  16  number of dropped records, saturates at 16'hFFFF

## Operation
- Timestamp:
  - ts is a TS_W counter; 0 in the first cycle after reset release.
  - Increments on every en=1 cycle and wraps modulo 2^TS_W. Holds when en=0.
- Capture:
  - A record is captured on a posedge with en=1 and |out_aktv=1.
  - Record contents: {ts, out_aktv, out_data}, using the ts value of that cycle.
  - en=0 blocks capture.
- Drop on full:
  - Full is evaluated from the registered count before the edge.
  - A capture while full is dropped even if a pop completes on the same edge.
  - A dropped capture sets overflow and increments drop_count (saturating).
- Packet format:
  - Beat 0 is the header: {ts zero-extended/truncated to 32 bits, mask zero-extended to 32 bits} (ts in [63:32]).
  - Then one beat per set mask bit, value of output_i, in ascending i.
  - Length is 1+popcount(mask); m_last is asserted on the final beat.
- Serializer FSM:
  - IDLE: wait for FIFO not empty; load the head record and go to HDR.
  - HDR: present the header. On handshake, go to DATA positioned at the lowest set bit.
  - DATA: present the current value. On handshake, advance to the next set bit via priority encoder. After the last one, pop the FIFO and go to IDLE, or go directly to HDR if another record is present (no bubble).
- Handshake rules:
  - A beat transfers when m_valid and m_ready are both high.
  - m_data and m_last are stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a transfer, except on reset.
  - en does not gate the serializer.

## Timing
- Reset values: m_valid=0, m_last=0, m_data=0, overflow=0, drop_count=0, FIFO empty, ts=0, FSM=IDLE.
  - Outputs are forced by async assert mid-packet; the partial packet and buffered records are discarded.
- Latency: with the FIFO empty and the FSM in IDLE, a capture at edge N presents the header with m_valid=1 in cycle N+1 (registered head load).
- Throughput: one beat per cycle with m_ready held high. Back-to-back packets are contiguous.
- Capture and pop on the same edge when not full: both take effect and count is unchanged.
- ts wrap: 2^TS_W-1 is followed by 0 and is recorded as-is.

## Structure
- Package verdict_pkg holds:
  - the record typedef (ts, mask, values array);
  - the FSM state enum {IDLE, HDR, DATA};
  - header field position constants;
  - the next-set-bit function.
- Sub-module verdict_fifo: synchronous record FIFO with registered count and full/empty flags, async reset.
- The top contains the ts counter, capture/drop logic, FSM and output registers.

## Test plan
- Single event: ts=5, aktv=14'h0005, output_0=1, output_2=-3, m_ready=1.
  - Cycle 6: header 64'h0000_0005_0000_0005.
  - Then 64'd1, then 64'hFFFF_FFFF_FFFF_FFFD with m_last=1. m_valid=0 afterwards.
- Backpressure: same event with m_ready=0 for 4 cycles at each beat.
  - m_data/m_last are held stable and m_valid stays 1; 3 beats total, no duplicates.
- All active: aktv=14'h3FFF, output_i=i+100.
  - 15 beats: header mask 0x3FFF, then 100..113 ascending, m_last on beat 15 only.
- Overflow: DEPTH=8, m_ready=0, 10 consecutive active cycles from ts=20.
  - drop_count=2 and overflow=1.
  - After m_ready=1: exactly 8 packets with ts 20..27, in order.
- en=0 for 5 cycles with aktv=14'h0001: no capture and ts frozen. After en=1, the next capture's ts is 5 lower than without the stall.
- Reset mid-packet: assert rst during beat 2 of a 3-beat packet with one more record queued.
  - m_valid falls immediately.
  - After release: no output, ts restarts at 0, overflow=0.
